// File: rtl/div8x4_seq.sv
// div8x4_seq: sequential restoring divider, 2N-bit dividend by N-bit divisor.
// Produces one quotient bit per clock, MSB first, and finishes after 2N steps.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request, sampled only while busy=0
//   dividend     2N-bit numerator, latched on an accepted start
//   divisor      N-bit denominator, latched on an accepted start
//   busy         high while a division is in progress
//   done         one-cycle pulse when quotient/remainder are updated
//   quotient     2N-bit registered quotient, held until the next completion
//   remainder    N-bit registered remainder, held until the next completion
//   div_by_zero  registered divide-by-zero flag, valid with done
//
// Optional feature: define DIV8X4_DZ_FAST_EN to finish a divide-by-zero one
// cycle after acceptance with div_by_zero=1. Without it the flag is tied 0
// and a zero divisor runs the full 2N steps to the same quotient/remainder.

module div8x4_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t         r_state;
  // Dividend shifts out at the MSB while quotient bits shift in at the LSB,
  // so after 2N steps this register holds the full quotient.
  logic [2*N-1:0] r_acc;
  logic [N-1:0]   r_dvs;
  // Only the low N bits of the partial remainder survive a step: after a
  // subtraction it is below the divisor, and the top bit of a trial value
  // is shifted out on the next step anyway.
  logic [N-1:0]   r_rem;
  logic [CW-1:0]  r_cnt;

  logic [N:0]     w_trial;
  logic           w_ge;
  logic [N-1:0]   w_rem_nxt;
  logic [2*N-1:0] w_acc_nxt;

  assign w_trial   = {r_rem, r_acc[2*N-1]};
  assign w_ge      = (w_trial >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? N'(w_trial - {1'b0, r_dvs})
                          : w_trial[N-1:0];
  assign w_acc_nxt = {r_acc[2*N-2:0], w_ge};

`ifdef DIV8X4_DZ_FAST_EN
  logic r_dz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_dz        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= dividend;
            r_dvs   <= divisor;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_dz    <= (divisor == '0);
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_dz) begin
            // Same values the natural algorithm would reach, one cycle in.
            quotient    <= '1;
            remainder   <= r_acc[N-1:0];
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              quotient    <= w_acc_nxt;
              remainder   <= w_rem_nxt;
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              busy        <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign div_by_zero = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= dividend;
            r_dvs   <= divisor;
            r_rem   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            quotient  <= w_acc_nxt;
            remainder <= w_rem_nxt;
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_div8x4_seq.sv
// tb_div8x4_seq: scoreboard bench for div8x4_seq (N=4).
// Directed vectors push expectations; a negedge monitor checks each done.

module tb_div8x4_seq;

`ifdef DIV8X4_DZ_FAST_EN
  localparam int   DZ_LAT  = 1;
  localparam logic DZ_FLAG = 1'b1;
`else
  localparam int   DZ_LAT  = 8;
  localparam logic DZ_FLAG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  div8x4_seq #(.N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         at;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none",
                 cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.nm, "_quotient"}, int'(quotient), int'(mon_e.q));
        chk({mon_e.nm, "_remainder"}, int'(remainder), int'(mon_e.r));
        chk({mon_e.nm, "_dz"}, int'(div_by_zero), int'(mon_e.dz));
        chk({mon_e.nm, "_done_cycle"}, cyc, mon_e.at);
        chk({mon_e.nm, "_busy_at_done"}, int'(busy), 0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic go(input logic [7:0] a, input logic [3:0] b,
                    input logic [7:0] eq, input logic [3:0] er,
                    input logic edz, input int lat, input string nm);
    exp_t e;
    int   w = 0;
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk({nm, "_wait_idle_timeout"}, int'(busy), 0);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    e.q  = eq;
    e.r  = er;
    e.dz = edz;
    e.at = cyc + lat;
    e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int w;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_dz", int'(div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    go(8'd15, 4'd5, 8'd3, 4'd0, 1'b0, 8, "d15_5");
    go(8'd48, 4'd12, 8'd4, 4'd0, 1'b0, 8, "d48_12");
    go(8'd46, 4'd9, 8'd5, 4'd1, 1'b0, 8, "d46_9");
    go(8'd154, 4'd14, 8'd11, 4'd0, 1'b0, 8, "d154_14");
    go(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8, "d255_1");
    go(8'd7, 4'd15, 8'd0, 4'd7, 1'b0, 8, "d7_15");
    go(8'd200, 4'd0, 8'hFF, 4'h8, DZ_FLAG, DZ_LAT, "d200_0");

    // Second start at E3 must be ignored.
    go(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8, "d100_3_ign");
    @(negedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 4'd9;
    @(negedge clk);
    start = 1'b0;

    // Reset at E4 aborts; quotient holds 33 from the previous run until then.
    go(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8, "d100_3_abort");
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_back());
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_dz", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_abort_busy", int'(busy), 0);
    go(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8, "d100_3_after_rst");

    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("pending_results", sb.size(), 0);
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
